// File: rtl/trv_mem_pkg.sv
// rtl/trv_mem_pkg.sv - funct3 codes, FSM state encoding and access-size helpers for the data-memory controller
package trv_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // One-hot controller states
    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        WAIT   = 4'b0010,
        ACCESS = 4'b0100,
        RESP   = 4'b1000
    } state_t;

    // Access size in bytes; the low two funct3 bits encode log2(size)
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   size_bytes = 4'd1;
            2'b01:   size_bytes = 4'd2;
            2'b10:   size_bytes = 4'd4;
            default: size_bytes = 4'd8;
        endcase
    endfunction

    // Doubleword and LWU encodings only exist on the 64-bit data path
    function automatic logic funct3_legal(input logic [2:0] funct3, input logic we, input logic wide);
        if (we) begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (wide && (funct3 == F3_D));
        end else begin
            funct3_legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                           (funct3 == F3_BU) || (funct3 == F3_HU) ||
                           (wide && ((funct3 == F3_D) || (funct3 == F3_WU)));
        end
    endfunction

endpackage

// File: rtl/trv_lsu_align.sv
// rtl/trv_lsu_align.sv - combinational byte-lane steering for stores and load extraction/extension
module trv_lsu_align
    import trv_mem_pkg::*;
#(
    parameter int B_WIDTH = 32,
    localparam int NB = B_WIDTH / 8,
    localparam int OB = $clog2(NB)
) (
    input  logic [OB-1:0]      lane,
    input  logic [2:0]         funct3,
    input  logic [B_WIDTH-1:0] wdata,
    input  logic [B_WIDTH-1:0] rword,
    output logic [NB-1:0]      be,
    output logic [B_WIDTH-1:0] wdata_sh,
    output logic [B_WIDTH-1:0] rdata_ext
);

    logic [3:0]         size;
    logic [OB+2:0]      bit_shift;
    logic [B_WIDTH-1:0] rsh;

    assign size      = size_bytes(funct3);
    assign bit_shift = {lane, 3'b000};
    assign wdata_sh  = wdata << bit_shift;
    assign rsh       = rword >> bit_shift;

    // Lane i is enabled when it falls inside [lane, lane + size)
    always_comb begin
        be = '0;
        for (int i = 0; i < NB; i++) begin
            be[i] = (i >= int'(lane)) && (i < int'(lane) + int'(size));
        end
    end

    // Right-aligned load value, sign- or zero-extended to the full data path
    always_comb begin
        case (funct3)
            F3_B:    rdata_ext = B_WIDTH'($signed(rsh[7:0]));
            F3_H:    rdata_ext = B_WIDTH'($signed(rsh[15:0]));
            F3_W:    rdata_ext = B_WIDTH'($signed(rsh[31:0]));
            F3_BU:   rdata_ext = B_WIDTH'(rsh[7:0]);
            F3_HU:   rdata_ext = B_WIDTH'(rsh[15:0]);
            F3_WU:   rdata_ext = B_WIDTH'(rsh[31:0]);
            default: rdata_ext = rsh;
        endcase
    end

endmodule

// File: rtl/trv_data_mem_ctrl.sv
// rtl/trv_data_mem_ctrl.sv - ready/valid data-memory controller with sub-word access, wait states and error responses
module trv_data_mem_ctrl
    import trv_mem_pkg::*;
#(
    parameter int          B_WIDTH     = 32,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [31:0]        req_addr,
    input  logic [2:0]         req_funct3,
    input  logic [B_WIDTH-1:0] req_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [B_WIDTH-1:0] rsp_rdata,
    output logic               rsp_err
);

    localparam int          NB        = B_WIDTH / 8;
    localparam int          OB        = $clog2(NB);
    localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) * 33'(NB);
    localparam logic [2:0]  WAIT_LAST = 3'((LATENCY > 0) ? (LATENCY - 1) : 0);

    state_t             state;
    logic [2:0]         wait_cnt;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [2:0]         funct3_q;
    logic [B_WIDTH-1:0] wdata_q;

    logic [B_WIDTH-1:0] mem [DEPTH_WORDS];

    logic [31:0]        req_off;
    logic [31:0]        size_mask;
    logic               req_bad;
    logic [31:0]        q_off;
    logic [AW-1:0]      word_idx;
    logic [OB-1:0]      lane;
    logic [B_WIDTH-1:0] rword;
    logic [NB-1:0]      st_be;
    logic [B_WIDTH-1:0] st_data;
    logic [B_WIDTH-1:0] ld_data;
    logic [NB-1:0]      unused_ld_be;
    logic [B_WIDTH-1:0] unused_ld_wdata;
    logic [B_WIDTH-1:0] unused_st_rdata;

    // The checks see the same values that get latched on acceptance
    assign req_off   = req_addr - BASE_ADDR;
    assign size_mask = 32'(size_bytes(req_funct3)) - 32'd1;
    assign req_bad   = !funct3_legal(req_funct3, req_we, B_WIDTH == 64) ||
                       ((req_addr & size_mask) != 32'd0) ||
                       ({1'b0, req_off} >= SPAN);

    assign q_off     = addr_q - BASE_ADDR;
    assign word_idx  = AW'(q_off >> OB);
    assign lane      = OB'(q_off);
    assign rword     = mem[word_idx];

    assign req_ready = (state == IDLE) && !rst;

    trv_lsu_align #(.B_WIDTH(B_WIDTH)) u_st_align (
        .lane      (lane),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .rword     (rword),
        .be        (st_be),
        .wdata_sh  (st_data),
        .rdata_ext (unused_st_rdata)
    );

    trv_lsu_align #(.B_WIDTH(B_WIDTH)) u_ld_align (
        .lane      (lane),
        .funct3    (funct3_q),
        .wdata     (wdata_q),
        .rword     (rword),
        .be        (unused_ld_be),
        .wdata_sh  (unused_ld_wdata),
        .rdata_ext (ld_data)
    );

    // Request/response FSM; an error response spends one settling cycle in RESP before rsp_valid rises
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 3'd0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            funct3_q  <= 3'd0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        if (req_bad) begin
                            state <= RESP;
                        end else if (LATENCY > 0) begin
                            state    <= WAIT;
                            wait_cnt <= WAIT_LAST;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state <= ACCESS;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ACCESS: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= we_q ? '0 : ld_data;
                end
                RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end else if (rsp_ready) begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Store commit with byte enables; a reset on the ACCESS edge cancels the write
    always_ff @(posedge clk) begin
        if (!rst && (state == ACCESS) && we_q) begin
            for (int i = 0; i < NB; i++) begin
                if (st_be[i]) mem[word_idx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_trv_data_mem_ctrl.sv
// tb/tb_trv_data_mem_ctrl.sv - self-checking bench for trv_data_mem_ctrl across widths and latencies
module tb_trv_data_mem_ctrl;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  vld;
    logic        we;
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [63:0] wdata;
    logic        rrdy;
    wire  [2:0]  rdy;
    wire  [2:0]  rv;
    wire  [2:0]  re;
    wire  [31:0] rd0;
    wire  [31:0] rd1;
    wire  [63:0] rd2;

    int     checks = 0;
    int     passes = 0;
    longint cyc = 0;

    logic        got_err;
    logic [63:0] got_rd;
    int          got_lat;
    bit          got_to;
    bit          got_busy_ok;
    bit          got_stable;
    bit          got_idle;
    longint      acc_cyc;
    logic        exp_err;
    logic [63:0] exp_rd;
    int          exp_lat;

    logic [7:0]  mm [3][512];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trv_data_mem_ctrl #(.B_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(0), .BASE_ADDR(32'h0), .INIT_FILE("")) d0 (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we), .req_addr(addr),
        .req_funct3(f3), .req_wdata(wdata[31:0]), .rsp_valid(rv[0]), .rsp_ready(rrdy),
        .rsp_rdata(rd0), .rsp_err(re[0]));

    trv_data_mem_ctrl #(.B_WIDTH(32), .DEPTH_WORDS(DEPTH), .LATENCY(3), .BASE_ADDR(32'h0), .INIT_FILE("")) d1 (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we), .req_addr(addr),
        .req_funct3(f3), .req_wdata(wdata[31:0]), .rsp_valid(rv[1]), .rsp_ready(rrdy),
        .rsp_rdata(rd1), .rsp_err(re[1]));

    trv_data_mem_ctrl #(.B_WIDTH(64), .DEPTH_WORDS(DEPTH), .LATENCY(1), .BASE_ADDR(32'h0), .INIT_FILE("")) d2 (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we), .req_addr(addr),
        .req_funct3(f3), .req_wdata(wdata), .rsp_valid(rv[2]), .rsp_ready(rrdy),
        .rsp_rdata(rd2), .rsp_err(re[2]));

    function automatic int lat_of(input int d);
        return (d == 0) ? 0 : (d == 1) ? 3 : 1;
    endfunction

    function automatic int nb_of(input int d);
        return (d == 2) ? 8 : 4;
    endfunction

    function automatic logic [63:0] rdsel(input int d);
        return (d == 0) ? {32'd0, rd0} : (d == 1) ? {32'd0, rd1} : rd2;
    endfunction

    // Reference: byte-addressed little-endian memory with RISC-V access rules
    task automatic model(input int d, input logic w, input logic [31:0] a, input logic [2:0] f, input logic [63:0] wd);
        int nb;
        int sz;
        bit legal;
        logic [63:0] v;
        nb = nb_of(d);
        sz = 1 << f[1:0];
        if (w) legal = (f <= 3'd2) || (nb == 8 && f == 3'd3);
        else   legal = (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) || (nb == 8 && f inside {3'd3, 3'd6});
        exp_err = !legal || ((a % sz) != 0) || (a >= 32'(DEPTH * nb));
        exp_rd  = 64'd0;
        exp_lat = exp_err ? 1 : lat_of(d) + 1;
        if (!exp_err) begin
            if (w) begin
                for (int i = 0; i < sz; i++) mm[d][a + i] = wd[8*i +: 8];
            end else begin
                v = 64'd0;
                for (int i = 0; i < sz; i++) v[8*i +: 8] = mm[d][a + i];
                if (!f[2] && sz < 8 && v[8*sz-1]) v = v | ~((64'd1 << (8*sz)) - 64'd1);
                if (nb == 4) v = v & 64'h0000_0000_FFFF_FFFF;
                exp_rd = v;
            end
        end
    endtask

    // Issue one request from a negedge, measure latency, hold off rsp_ready, then hand shake
    task automatic do_req(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                          input logic [63:0] wd, input int hold);
        bit found;
        got_to = 0; got_busy_ok = 1; got_stable = 1; got_lat = -1; found = 0;
        we = w; addr = a; f3 = f; wdata = wd; vld[d] = 1'b1;
        for (int n = 0; n < 20 && !rdy[d]; n++) @(negedge clk);
        if (!rdy[d]) got_to = 1;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        vld[d] = 1'b0;
        we = 1'($urandom); addr = $urandom; f3 = 3'($urandom); wdata = {$urandom, $urandom};
        for (int m = 0; m < 30; m++) begin
            @(negedge clk);
            if (rdy[d]) got_busy_ok = 0;
            if (rv[d]) begin
                got_lat = m;
                found = 1;
                break;
            end
        end
        if (!found) got_to = 1;
        got_err = re[d];
        got_rd  = rdsel(d);
        repeat (hold) begin
            @(negedge clk);
            if (rv[d] !== 1'b1 || re[d] !== got_err || rdsel(d) !== got_rd || rdy[d] !== 1'b0) got_stable = 0;
        end
        rrdy = 1'b1;
        @(posedge clk);
        #1;
        rrdy = 1'b0;
        @(negedge clk);
        got_idle = (rdy[d] === 1'b1) && (rv[d] === 1'b0);
    endtask

    task automatic xact(input int d, input logic w, input logic [31:0] a, input logic [2:0] f,
                        input logic [63:0] wd, input int hold);
        do_req(d, w, a, f, wd, hold);
        model(d, w, a, f, wd);
    endtask

    task automatic test_reset();
        rst = 1'b1; vld = 3'b000; rrdy = 1'b0; we = 1'b0; addr = 32'd0; f3 = 3'd0; wdata = 64'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (rdy !== 3'b000 || rv !== 3'b000 || re !== 3'b000)
            $display("FAIL reset_ctrl: ready=%b valid=%b err=%b, required all 000", rdy, rv, re);
        else passes++;
        checks++;
        if (rd0 !== 32'd0 || rd1 !== 32'd0 || rd2 !== 64'd0)
            $display("FAIL reset_rdata: %h %h %h, required 0", rd0, rd1, rd2);
        else passes++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (rdy !== 3'b111) $display("FAIL reset_release_ready: %b, required 111", rdy);
        else passes++;
    endtask

    task automatic init_mem();
        bit any_err;
        any_err = 0;
        for (int d = 0; d < 3; d++) begin
            for (int wi = 0; wi < DEPTH; wi++) begin
                xact(d, 1'b1, 32'(wi * nb_of(d)), (d == 2) ? 3'd3 : 3'd2, 64'd0, 0);
                if (got_err !== 1'b0 || got_to) any_err = 1;
            end
        end
        checks++;
        if (any_err) $display("FAIL init_stores: an init store errored or timed out, required none");
        else passes++;
    endtask

    task automatic test_directed_32();
        xact(0, 1'b1, 32'h10, 3'd2, 64'hDEADBEEF, 0);
        checks++;
        if (got_lat !== 1 || got_err !== 1'b0 || got_rd !== 64'd0)
            $display("FAIL sw_resp: lat=%0d err=%b rd=%h, required 1 0 0", got_lat, got_err, got_rd);
        else passes++;
        xact(0, 1'b0, 32'h10, 3'd2, 64'd0, 0);
        checks++;
        if (got_lat !== 1 || got_err !== 1'b0 || got_rd !== 64'hDEADBEEF)
            $display("FAIL lw_resp: lat=%0d err=%b rd=%h, required 1 0 deadbeef", got_lat, got_err, got_rd);
        else passes++;
        xact(0, 1'b0, 32'h13, 3'd0, 64'd0, 0);
        checks++;
        if (got_rd !== 64'hFFFF_FFDE) $display("FAIL lb_sign: %h, required ffffffde", got_rd);
        else passes++;
        xact(0, 1'b0, 32'h13, 3'd4, 64'd0, 0);
        checks++;
        if (got_rd !== 64'h0000_00DE) $display("FAIL lbu_zero: %h, required 000000de", got_rd);
        else passes++;
        xact(0, 1'b0, 32'h12, 3'd1, 64'd0, 0);
        checks++;
        if (got_rd !== 64'hFFFF_DEAD) $display("FAIL lh_sign: %h, required ffffdead", got_rd);
        else passes++;
        xact(0, 1'b1, 32'h11, 3'd0, 64'h55, 0);
        xact(0, 1'b0, 32'h10, 3'd2, 64'd0, 0);
        checks++;
        if (got_rd !== 64'hDEAD_55EF) $display("FAIL sb_merge: %h, required dead55ef", got_rd);
        else passes++;
    endtask

    task automatic test_errors();
        xact(0, 1'b0, 32'h12, 3'd2, 64'd0, 0);
        checks++;
        if (got_err !== 1'b1 || got_rd !== 64'd0 || got_lat !== 1)
            $display("FAIL err_misaligned: err=%b rd=%h lat=%0d, required 1 0 1", got_err, got_rd, got_lat);
        else passes++;
        xact(0, 1'b1, 32'(DEPTH * 4), 3'd2, 64'hFFFF_FFFF, 0);
        checks++;
        if (got_err !== 1'b1) $display("FAIL err_range: err=%b, required 1", got_err);
        else passes++;
        xact(0, 1'b0, 32'h0, 3'd2, 64'd0, 0);
        checks++;
        if (got_err !== 1'b0 || got_rd !== 64'd0)
            $display("FAIL err_range_nowrite: err=%b rd=%h, required 0 0", got_err, got_rd);
        else passes++;
        xact(0, 1'b0, 32'h8, 3'd3, 64'd0, 0);
        checks++;
        if (got_err !== 1'b1 || got_rd !== 64'd0)
            $display("FAIL err_funct3: err=%b rd=%h, required 1 0", got_err, got_rd);
        else passes++;
    endtask

    task automatic test_backpressure();
        xact(1, 1'b1, 32'h40, 3'd2, 64'hA5A5_5A5A, 0);
        xact(1, 1'b0, 32'h40, 3'd2, 64'd0, 5);
        checks++;
        if (got_lat !== 4 || got_to) $display("FAIL bp_latency: %0d, required 4", got_lat);
        else passes++;
        checks++;
        if (got_rd !== 64'hA5A5_5A5A || got_err !== 1'b0)
            $display("FAIL bp_data: rd=%h err=%b, required a5a55a5a 0", got_rd, got_err);
        else passes++;
        checks++;
        if (!got_stable || !got_busy_ok)
            $display("FAIL bp_hold: stable=%0d ready_low=%0d, required 1 1", got_stable, got_busy_ok);
        else passes++;
        checks++;
        if (!got_idle) $display("FAIL bp_return_idle: idle=%0d, required 1", got_idle);
        else passes++;
    endtask

    task automatic test_reset_mid_wait();
        bit saw_rsp;
        bit outs_zero;
        xact(1, 1'b1, 32'h20, 3'd2, 64'hCAFE_F00D, 0);
        we = 1'b1; addr = 32'h20; f3 = 3'd2; wdata = 64'h1234_5678; vld[1] = 1'b1;
        @(posedge clk);
        #1;
        vld[1] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        outs_zero = 1;
        repeat (2) begin
            @(negedge clk);
            if (rdy !== 3'b000 || rv !== 3'b000 || re !== 3'b000 || rd1 !== 32'd0) outs_zero = 0;
        end
        checks++;
        if (!outs_zero) $display("FAIL rst_outputs: ready=%b valid=%b err=%b rd=%h, required all 0", rdy, rv, re, rd1);
        else passes++;
        rst = 1'b0;
        saw_rsp = 0;
        repeat (6) begin
            @(negedge clk);
            if (rv[1] !== 1'b0) saw_rsp = 1;
        end
        checks++;
        if (saw_rsp) $display("FAIL rst_dropped: valid seen=%0d, required 0", saw_rsp);
        else passes++;
        xact(1, 1'b0, 32'h20, 3'd2, 64'd0, 0);
        checks++;
        if (got_rd !== 64'hCAFE_F00D) $display("FAIL rst_no_commit: %h, required cafef00d", got_rd);
        else passes++;
    endtask

    task automatic test_wide();
        xact(2, 1'b1, 32'h8, 3'd3, 64'h0123_4567_89AB_CDEF, 0);
        checks++;
        if (got_err !== 1'b0 || got_lat !== 2) $display("FAIL sd_resp: err=%b lat=%0d, required 0 2", got_err, got_lat);
        else passes++;
        xact(2, 1'b0, 32'hC, 3'd6, 64'd0, 0);
        checks++;
        if (got_rd !== 64'h0000_0000_0123_4567) $display("FAIL lwu_64: %h, required 0000000001234567", got_rd);
        else passes++;
        xact(2, 1'b0, 32'h8, 3'd2, 64'd0, 0);
        checks++;
        if (got_rd !== 64'hFFFF_FFFF_89AB_CDEF) $display("FAIL lw_64: %h, required ffffffff89abcdef", got_rd);
        else passes++;
        xact(2, 1'b0, 32'h8, 3'd3, 64'd0, 0);
        checks++;
        if (got_rd !== 64'h0123_4567_89AB_CDEF) $display("FAIL ld_64: %h, required 0123456789abcdef", got_rd);
        else passes++;
    endtask

    task automatic test_back_to_back();
        longint first;
        for (int d = 0; d < 3; d++) begin
            xact(d, 1'b0, 32'h0, 3'd2, 64'd0, 0);
            first = acc_cyc;
            xact(d, 1'b0, 32'h4, 3'd2, 64'd0, 0);
            checks++;
            if (acc_cyc - first !== longint'(lat_of(d) + 3))
                $display("FAIL b2b_spacing d%0d: %0d cycles, required %0d", d, acc_cyc - first, lat_of(d) + 3);
            else passes++;
        end
    endtask

    task automatic test_random();
        logic [31:0] a;
        int span;
        for (int d = 0; d < 3; d++) begin
            span = DEPTH * nb_of(d);
            for (int k = 0; k < 50; k++) begin
                if ($urandom_range(0, 9) == 0) a = 32'(span + int'($urandom_range(0, 31)));
                else a = 32'($urandom_range(0, span - 1));
                xact(d, 1'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), {$urandom, $urandom},
                     int'($urandom_range(0, 2)));
                checks++;
                if (got_to || got_err !== exp_err || got_rd !== exp_rd || got_lat !== exp_lat || !got_stable || !got_idle)
                    $display("FAIL rand d%0d #%0d addr=%h: err=%b rd=%h lat=%0d stable=%0d idle=%0d, required err=%b rd=%h lat=%0d",
                             d, k, a, got_err, got_rd, got_lat, got_stable, got_idle, exp_err, exp_rd, exp_lat);
                else passes++;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        init_mem();
        test_directed_32();
        test_errors();
        test_backpressure();
        test_reset_mid_wait();
        test_wide();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
